// File: rtl/data_mem_responder.sv
// data_mem_responder: backing data memory for the memory stage.
// Accepts one load/store at a time, waits LATENCY cycles, performs the
// access on an internal word array and holds the response until taken.
module data_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  // Reject parameter sets the counter or byte lanes cannot represent.
  generate
    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
      $fatal(1, "data_mem_responder: LATENCY must be in 1..255");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
      $fatal(1, "data_mem_responder: DATA_W must be a multiple of 8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_ready;
  logic                r_rsp_valid;
  logic                r_err;
  logic                r_rd_sel;    // response carries load data
  logic [7:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_mem_q;     // registered array read
  logic [DATA_W-1:0]   r_mem [DEPTH_WORDS];

  logic                w_accept;
  logic                w_commit;
  logic                w_handshake;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_we;
  logic [BE_W-1:0]     w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic [ADDR_W-1:0]   w_word;
  logic [IDX_W-1:0]    w_idx;
  logic                w_err;
  logic                w_mem_en;

  // With LATENCY==1 the commit happens on the accept edge, so the live
  // request fields are used; otherwise the latched copy is used.
  assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_be    = (r_state == S_IDLE) ? req_be    : r_be;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_word   = w_addr >> OFF_W;
  assign w_idx    = w_word[IDX_W-1:0];
  assign w_err    = (|(w_addr & OFF_MASK)) || (w_word >= ADDR_W'(DEPTH_WORDS));
  assign w_mem_en = w_commit && !w_err && !rst;

  // Next-state logic and the per-cycle event strobes.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && r_ready) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_commit     = 1'b1;
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 8'd1) begin
          w_commit     = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_handshake  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Request latch, latency counter and response flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_cnt       <= 8'd0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_we    <= req_we;
        r_be    <= req_be;
        r_wdata <= req_wdata;
        r_cnt   <= CNT_INIT;
        r_ready <= 1'b0;
      end else if (r_state == S_IDLE) begin
        r_ready <= 1'b1;
      end
      if (r_state == S_WAIT) r_cnt <= r_cnt - 8'd1;
      if (w_commit) begin
        r_rsp_valid <= 1'b1;
        r_err       <= w_err;
        r_rd_sel    <= !w_we && !w_err;
      end
      if (w_handshake) begin
        r_rsp_valid <= 1'b0;
        r_err       <= 1'b0;
        r_rd_sel    <= 1'b0;
        r_ready     <= 1'b1;
      end
    end
  end

  // Word array: byte-enabled write and registered read at the commit edge.
  always_ff @(posedge clk) begin
    if (w_mem_en) begin
      if (w_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end else begin
        r_mem_q <= r_mem[w_idx];
      end
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_err;
  assign rsp_rdata = r_rd_sel ? r_mem_q : '0;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the load/store requests issued by memory_stage and answered back to it. It accepts one request at a time over a valid/ready handshake, waits a programmable latency, then performs the access on an internal word array. It returns the read data or a write acknowledge over a second valid/ready handshake. It acts as the backing data memory model for pipeline simulation and for stall-path verification.

Parameters:
ADDR_W, 32, request byte-address width
DATA_W, 32, data width; must be a multiple of 8
DEPTH_WORDS, 1024, number of DATA_W words in the array
LATENCY, 3, cycles from the accept edge to the first rsp_valid cycle; legal range 1..255

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_addr  in  ADDR_W  byte address
req_we  in  1  1 = store, 0 = load
req_be  in  DATA_W/8  byte enables for stores; ignored for loads
req_wdata  in  DATA_W  store data
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts the response
rsp_rdata  out  DATA_W  load data; 0 for stores and for errors
rsp_err  out  1  request was misaligned or out of range

Behaviour:
- Reset, asynchronous: state IDLE, req_ready=0 while rst is high, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Reset does not clear the array. A pending request is dropped, and a store not yet committed is never written.
- req_ready is registered. It rises on the first clk edge after rst deasserts.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. Accept occurs when req_valid && req_ready at an edge. At accept:
  - latch addr, we, be, wdata;
  - counter := LATENCY-1;
  - req_ready := 0;
  - next state is RESP if LATENCY==1, otherwise WAIT.
- WAIT: counter decrements each edge. At the edge where counter==1, go to RESP.
- RESP is entered at the commit edge, and the access is performed at that edge:
  - Load: rsp_rdata := array[idx].
  - Store: for each byte b with be[b]=1, array[idx][8b+7:8b] := wdata byte b. rsp_rdata := 0.
  - rsp_valid := 1.
- Net timing: rsp_valid is first high exactly LATENCY cycles after the accept cycle.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready. At that edge: rsp_valid := 0, rsp_rdata := 0, rsp_err := 0, req_ready := 1, go to IDLE.
- A new request cannot be accepted in the same cycle as a response handshake. Maximum throughput is one request per LATENCY+1 cycles.
- Index: idx = addr >> log2(DATA_W/8).
- Error: asserted when the low log2(DATA_W/8) address bits are non-zero, or when idx >= DEPTH_WORDS.
  - On error, no array write occurs, rsp_rdata=0 and rsp_err=1. Latency is unchanged.
- Store with be all-zero: no bytes change, normal ack, rsp_err=0.
- req_valid while req_ready=0: ignored. The requester must hold it, and its signals are not sampled.
- rsp_ready high outside RESP: no effect.
- The counter is 8 bits and never wraps because LATENCY <= 255. Elaboration fails on LATENCY==0 or DATA_W%8 != 0.

Test Plan:
- Store then load, LATENCY=3: store addr 0x10, be=0xF, wdata 0xDEADBEEF accepted at cycle 0 -> rsp_valid at cycle 3 with rdata 0, err 0. Load 0x10 -> rdata 0xDEADBEEF exactly 3 cycles after its accept.
- Partial store: preload 0x11223344 at 0x20, store be=0b0101, wdata 0xAABBCCDD -> a following load returns 0x11BB33DD.
- Backpressure: load with rsp_ready held low for 4 cycles after rsp_valid -> rsp_valid/rdata held stable for all 4 cycles, req_ready stays 0, and a new req_valid is not accepted until the cycle after the handshake.
- Errors: load 0x0000_0002 -> err=1, rdata 0. Store to byte address 4*DEPTH_WORDS -> err=1, and a later load of word 0 shows it unchanged.
- LATENCY=1: back-to-back loads with rsp_ready tied 1 -> responses every 2 cycles, rsp_valid one cycle after each accept.
- Reset mid-WAIT: store 0x55AA55AA to 0x40 (previously 0), assert rst one cycle after accept -> outputs zero immediately, no response appears, and a post-reset load of 0x40 returns 0.
